// File: rtl/rt_out_arbiter_if.sv
// Handshake bundle between one router output arbiter and its input channels / downstream link.
// The master side drives requests, route selects, flits and the downstream ack.
`timescale 1ns/1ps
interface rt_out_arbiter_if #(
    parameter int n    = 32,
    parameter int N_IN = 5
);
    logic [N_IN-1:0]   in_req;
    logic [N_IN-1:0]   in_want;
    logic [N_IN*n-1:0] in_data;
    logic [N_IN-1:0]   in_ack;
    logic              out_req;
    logic [n-1:0]      out_data;
    logic              out_ack;

    modport master (
        output in_req, in_want, in_data, out_ack,
        input  in_ack, out_req, out_data
    );

    modport slave (
        input  in_req, in_want, in_data, out_ack,
        output in_ack, out_req, out_data
    );
endinterface

// File: rtl/rt_out_arbiter.sv
// Round-robin arbiter for one router output port: picks a pending input, forwards its flit on a
// two-phase handshake, and acks the source only once the downstream has acked.
`timescale 1ns/1ps
module rt_out_arbiter #(
    parameter int n     = 32,
    parameter int N_IN  = 5,
    parameter int CNT_W = 16,
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                clk,
    input  logic                rst,
    rt_out_arbiter_if.slave     bus,
    output logic                grant_valid,
    output logic [IDX_W-1:0]    grant_idx,
    output logic [CNT_W-1:0]    xfer_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_RELEASE  = 2'd2
    } state_e;

    state_e            state_q,       state_d;
    logic              out_req_q,     out_req_d;
    logic [n-1:0]      out_data_q,    out_data_d;
    logic [N_IN-1:0]   in_ack_q,      in_ack_d;
    logic              grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]  grant_idx_q,   grant_idx_d;
    logic [IDX_W-1:0]  rr_ptr_q,      rr_ptr_d;
    logic [CNT_W-1:0]  xfer_count_q,  xfer_count_d;

    logic [N_IN-1:0]   pending_s;
    logic              any_pending_s;
    logic [IDX_W-1:0]  winner_s;

    // Index base+off folded back into 0..N_IN-1 (both operands are already below N_IN).
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(N_IN)) begin
            sum = sum - 32'(N_IN);
        end else begin
            sum = sum;
        end
        return IDX_W'(sum);
    endfunction

    assign pending_s = (bus.in_req ^ in_ack_q) & bus.in_want;

    // Winner search; scanning from the far end lets the nearest pending index overwrite the rest.
    always_comb begin
        any_pending_s = |pending_s;
        winner_s      = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            winner_s = pending_s[wrap_idx(rr_ptr_q, k)] ? wrap_idx(rr_ptr_q, k) : winner_s;
        end
    end

    // Next-state and datapath updates for the grant / wait / release sequence.
    always_comb begin
        state_d       = state_q;
        out_req_d     = out_req_q;
        out_data_d    = out_data_q;
        in_ack_d      = in_ack_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        rr_ptr_d      = rr_ptr_q;
        xfer_count_d  = xfer_count_q;
        case (state_q)
            S_IDLE: begin
                if (any_pending_s) begin
                    out_data_d    = bus.in_data[winner_s*n +: n];
                    out_req_d     = ~out_req_q;
                    grant_idx_d   = winner_s;
                    grant_valid_d = 1'b1;
                    state_d       = S_WAIT_ACK;
                end else begin
                    state_d       = S_IDLE;
                end
            end
            S_WAIT_ACK: begin
                if (bus.out_ack == out_req_q) begin
                    in_ack_d[grant_idx_q] = ~in_ack_q[grant_idx_q];
                    xfer_count_d          = xfer_count_q + CNT_W'(1);
                    state_d               = S_RELEASE;
                end else begin
                    state_d               = S_WAIT_ACK;
                end
            end
            S_RELEASE: begin
                // Pointer moves past the served input so it drops to lowest priority.
                rr_ptr_d      = (grant_idx_q == IDX_W'(N_IN - 1)) ? '0 : grant_idx_q + IDX_W'(1);
                grant_valid_d = 1'b0;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-transfer drops the flit unacked.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            out_req_q     <= 1'b0;
            out_data_q    <= '0;
            in_ack_q      <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            rr_ptr_q      <= '0;
            xfer_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            out_req_q     <= out_req_d;
            out_data_q    <= out_data_d;
            in_ack_q      <= in_ack_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            rr_ptr_q      <= rr_ptr_d;
            xfer_count_q  <= xfer_count_d;
        end
    end

    assign bus.in_ack   = in_ack_q;
    assign bus.out_req  = out_req_q;
    assign bus.out_data = out_data_q;
    assign grant_valid  = grant_valid_q;
    assign grant_idx    = grant_idx_q;
    assign xfer_count   = xfer_count_q;

endmodule

// File: tb/tb_rt_out_arbiter.sv
// Directed bench for rt_out_arbiter: drives sources and the downstream ack by hand and checks
// every output against a bench-side model of out_req, in_ack and the transfer count.
`timescale 1ns/1ps
module tb_rt_out_arbiter;

    localparam int W  = 32;
    localparam int NI = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        grant_valid;
    logic [2:0]  grant_idx;
    logic [15:0] xfer_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        exp_req;
    logic [4:0]  exp_ack;
    logic [15:0] exp_cnt;

    rt_out_arbiter_if #(.n(W), .N_IN(NI)) bus ();

    rt_out_arbiter #(.n(W), .N_IN(NI), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .xfer_count  (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_data(input int i, input logic [31:0] d);
        bus.in_data[i*W +: W] = d;
    endtask

    task automatic toggle_req(input int i);
        bus.in_req[i] = ~bus.in_req[i];
    endtask

    // Sources and downstream share rst, so they restart at zero alongside the DUT.
    task automatic apply_reset();
        rst         = 1'b1;
        bus.in_req  = '0;
        bus.out_ack = 1'b0;
        tick();
        exp_req = 1'b0;
        exp_ack = '0;
        exp_cnt = '0;
        rst     = 1'b0;
    endtask

    // One edge in IDLE with something pending: expect the grant and the flit.
    task automatic grant_phase(input int idx, input logic [31:0] data);
        tick();
        exp_req = ~exp_req;
        chk("grant.out_req",     32'(bus.out_req),   32'(exp_req));
        chk("grant.out_data",    bus.out_data,       data);
        chk("grant.grant_idx",   32'(grant_idx),     32'(idx));
        chk("grant.grant_valid", 32'(grant_valid),   32'd1);
    endtask

    // Stall for 'delay' cycles, then ack downstream and expect ack to the source plus release.
    task automatic complete_phase(input int idx, input int delay, input logic [31:0] data);
        for (int c = 0; c < delay; c++) begin
            tick();
            chk("stall.in_ack",   32'(bus.in_ack), 32'(exp_ack));
            chk("stall.out_data", bus.out_data,    data);
        end
        bus.out_ack = ~bus.out_ack;
        tick();
        exp_ack[idx] = ~exp_ack[idx];
        exp_cnt      = exp_cnt + 16'd1;
        chk("done.in_ack",     32'(bus.in_ack),  32'(exp_ack));
        chk("done.xfer_count", 32'(xfer_count),  32'(exp_cnt));
        tick();
        chk("release.grant_valid", 32'(grant_valid), 32'd0);
        chk("release.out_data",    bus.out_data,     data);
    endtask

    task automatic serve(input int idx, input logic [31:0] data);
        grant_phase(idx, data);
        complete_phase(idx, 0, data);
    endtask

    initial begin
        rst         = 1'b1;
        bus.in_req  = '0;
        bus.in_want = '0;
        bus.in_data = '0;
        bus.out_ack = 1'b0;
        exp_req = 1'b0;
        exp_ack = '0;
        exp_cnt = '0;
        repeat (2) tick();
        chk("rst.out_req",     32'(bus.out_req),  32'd0);
        chk("rst.out_data",    bus.out_data,      32'd0);
        chk("rst.in_ack",      32'(bus.in_ack),   32'd0);
        chk("rst.grant_valid", 32'(grant_valid),  32'd0);
        chk("rst.grant_idx",   32'(grant_idx),    32'd0);
        chk("rst.xfer_count",  32'(xfer_count),   32'd0);
        rst = 1'b0;

        // Single transfer on input 2, downstream acks after 4 cycles.
        bus.in_want = 5'b00100;
        set_data(2, 32'hA000_0001);
        toggle_req(2);
        grant_phase(2, 32'hA000_0001);
        complete_phase(2, 4, 32'hA000_0001);

        // All five pending from pointer 0: strict order 0..4, then pointer wraps to 0.
        apply_reset();
        for (int i = 0; i < NI; i++) set_data(i, 32'hB000_0000 + 32'(i));
        bus.in_want = 5'b11111;
        bus.in_req  = 5'b11111;
        for (int i = 0; i < NI; i++) serve(i, 32'hB000_0000 + 32'(i));
        toggle_req(4);
        toggle_req(0);
        serve(0, 32'hB000_0000);
        serve(4, 32'hB000_0004);

        // Inputs 1 and 3 re-requesting with pointer at 2: 3,1,3,1; input 4 joins later.
        bus.in_want = 5'b01010;
        toggle_req(1);
        serve(1, 32'hB000_0001);
        toggle_req(1);
        toggle_req(3);
        serve(3, 32'hB000_0003);
        toggle_req(3);
        serve(1, 32'hB000_0001);
        toggle_req(1);
        serve(3, 32'hB000_0003);
        toggle_req(3);
        serve(1, 32'hB000_0001);
        bus.in_want = 5'b11010;
        toggle_req(4);
        toggle_req(1);
        serve(3, 32'hB000_0003);
        serve(4, 32'hB000_0004);
        serve(1, 32'hB000_0001);

        // Pending without in_want never wins; dropping in_want mid-flight does not abort.
        bus.in_want = 5'b00000;
        toggle_req(0);
        repeat (3) begin
            tick();
            chk("nowant.grant_valid", 32'(grant_valid), 32'd0);
            chk("nowant.out_req",     32'(bus.out_req), 32'(exp_req));
        end
        bus.in_want = 5'b00001;
        grant_phase(0, 32'hB000_0000);
        bus.in_want = 5'b00000;
        set_data(0, 32'hDEAD_BEEF);
        complete_phase(0, 2, 32'hB000_0000);

        // Reset while waiting for downstream: everything returns to zero, source not acked.
        bus.in_want = 5'b00100;
        toggle_req(2);
        grant_phase(2, 32'hB000_0002);
        tick();
        apply_reset();
        chk("midrst.out_req",     32'(bus.out_req), 32'd0);
        chk("midrst.in_ack",      32'(bus.in_ack),  32'd0);
        chk("midrst.grant_valid", 32'(grant_valid), 32'd0);
        chk("midrst.xfer_count",  32'(xfer_count),  32'd0);
        chk("midrst.grant_idx",   32'(grant_idx),   32'd0);
        chk("midrst.out_data",    bus.out_data,     32'd0);
        tick();
        chk("postrst.grant_valid", 32'(grant_valid), 32'd0);

        // Counter wrap plus a 100-cycle downstream stall with the flit held steady.
        force dut.xfer_count_q = 16'hFFFF;
        tick();
        release dut.xfer_count_q;
        tick();
        exp_cnt = 16'hFFFF;
        chk("wrap.preset", 32'(xfer_count), 32'(exp_cnt));
        toggle_req(2);
        grant_phase(2, 32'hB000_0002);
        complete_phase(2, 100, 32'hB000_0002);
        chk("wrap.zero", 32'(xfer_count), 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
